imm_share_arb: RTL
==================

# imm_share_arb

Two-port arbiter and sequencer that shares the single immediate generator (instruction + imm_type in, 32-bit imm out, purely combinational) between two requesters, e.g. the decode stage and the branch-target precompute unit. Each requester presents an instruction and an imm_type over a valid/ready handshake. The block grants one requester at a time with round-robin priority, drives the shared generator from a latched copy of the request, registers the result, and returns it on that requester's response channel with backpressure.

## Interface
- RR_INIT, default 0, requester favoured after reset (0 or 1).
- clock  in  1  sole clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- req0_valid / req1_valid  in  1  requester i has a request.
- req0_ready / req1_ready  out  1  request i accepted this cycle (fire = valid & ready).
- req0_instr / req1_instr  in  32  instruction word.
- req0_type / req1_type  in  3  imm_type.
- rsp0_valid / rsp1_valid  out  1  result for requester i available.
- rsp0_ready / rsp1_ready  in  1  requester i consumes result.
- rsp0_imm / rsp1_imm  out  32  result; valid only while rspi_valid.
- gen_instr  out  32  to shared generator.
- gen_type  out  3  to shared generator.
- gen_imm  in  32  from shared generator.
- busy  out  1  state != IDLE.

## Operation
- imm_type encoding (generator contract): 1 I sign-ext, 2 U, 3 constant 4, 4 S sign-ext, 5 shamt instr[24:20] zero-ext, 6 instr[31:20] zero-ext, 0/7 yields 0. The block passes type through unchecked.
- State: IDLE, GEN, RESP; regs owner (1b), prio (1b), lat_instr (32), lat_type (3), res (32).
- IDLE: if either valid, grant = prio if req[prio]_valid, else the other. Assert ready only to the grantee (combinational from valid/prio). On fire, latch instr/type, set owner = grant, go to GEN. No valid: stay.
- GEN: gen_instr/gen_type = latched values; res <= gen_imm; go to RESP. No ready asserted.
- RESP: rsp[owner]_valid = 1, rsp[owner]_imm = res; other rsp_valid = 0. When rsp[owner]_ready: prio <= ~owner. Same cycle, arbitrate new requests exactly as in IDLE, using the updated priority (~owner). On fire, latch the request and go to GEN, else go to IDLE. Without rsp_ready: hold RESP, res stable, no request accepted.
- gen_type = 0 and gen_instr = 0 outside GEN, so generator output is 0 when unused.
- Requester sees at most one outstanding request; its req_ready never asserts while it owns a pending result.

## Timing
- Reset values: state IDLE, prio = RR_INIT, owner 0, lat_* 0, res 0. All req_ready, rsp_valid, busy = 0; gen_instr/gen_type = 0.
- Latency: request fire in cycle t, rsp_valid high in cycle t+2.
- Throughput: with rsp_ready tied high, one result per 2 cycles (RESP->GEN back-to-back).
- Both valid in IDLE: prio requester wins; loser is served next if still valid (no starvation, max wait one transaction).
- Request inputs may change while not fired; only the values at fire are used.
- Reset asserted mid-transaction (GEN or RESP): pending result is dropped, outputs go to reset values asynchronously, and no rsp_valid appears after release.
- rsp_imm is X-free: it equals res (reset 0) whenever driven.

## Test plan
- Single I-type: req0 instr 0xFFF00093 type 1 at t -> rsp0_valid at t+2, imm 0xFFFFFFFF, req0_ready only at t.
- U/S types: req1 0x12345037 type 2 -> 0x12345000; then req1 0xFE20AE23 type 4 -> 0xFFFFFFFC.
- Shamt/zero-ext/const: 0x01F09093 type 5 -> 0x0000001F; 0xFFF00073 type 6 -> 0x00000FFF; any instr type 3 -> 0x00000004; type 7 -> 0.
- Contention: both valid every cycle, rsp ready high, RR_INIT=0 -> grants alternate 0,1,0,1, one result per 2 cycles, each rsp on the correct port.
- Backpressure: rsp0_ready low 5 cycles -> rsp0_valid/imm held stable, req1_ready stays 0 despite req1_valid. Raise ready -> req1 accepted in the same cycle.
- Async reset asserted during GEN (between clock edges) -> busy/rsp/ready drop at once, prio = RR_INIT, no stale response after release.

Source files
------------

// File: rtl/imm_share_arb.sv
// rtl/imm_share_arb.sv - round-robin two-port arbiter sharing one immediate generator
module imm_share_arb #(
   parameter logic RR_INIT = 1'b0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [31:0] req0_instr,
   input  logic [2:0]  req0_type,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [31:0] req1_instr,
   input  logic [2:0]  req1_type,
   output logic        rsp0_valid,
   input  logic        rsp0_ready,
   output logic [31:0] rsp0_imm,
   output logic        rsp1_valid,
   input  logic        rsp1_ready,
   output logic [31:0] rsp1_imm,
   output logic [31:0] gen_instr,
   output logic [2:0]  gen_type,
   input  logic [31:0] gen_imm,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, GEN, RESP} state_t;

   state_t      state;
   logic        owner;
   logic        prio;
   logic [31:0] lat_instr;
   logic [2:0]  lat_type;
   logic [31:0] res;

   logic        rsp_fire;
   logic        arb_en;
   logic        eff_prio;
   logic        grant;
   logic        fire;

   // Arbitration: open in IDLE, or in RESP on the cycle the owner takes its result;
   // in that case the owner just got served, so the other side is favoured.
   always_comb begin
      rsp_fire   = (state == RESP) && (owner ? rsp1_ready : rsp0_ready);
      arb_en     = (state == IDLE) || rsp_fire;
      eff_prio   = (state == RESP) ? ~owner : prio;
      grant      = (eff_prio ? req1_valid : req0_valid) ? eff_prio : ~eff_prio;
      req0_ready = ~reset & arb_en & ~grant & req0_valid;
      req1_ready = ~reset & arb_en & grant & req1_valid;
      fire       = req0_ready | req1_ready;
   end

   // Output decode: the generator sees zeros unless it is in use, and the result
   // is presented only on the owner's response channel.
   always_comb begin
      gen_instr  = (state == GEN) ? lat_instr : 32'd0;
      gen_type   = (state == GEN) ? lat_type : 3'd0;
      rsp0_valid = (state == RESP) && !owner;
      rsp1_valid = (state == RESP) && owner;
      rsp0_imm   = res;
      rsp1_imm   = res;
      busy       = (state != IDLE);
   end

   // Sequencer: accept -> generate (one cycle) -> hold result until consumed.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         owner     <= 1'b0;
         prio      <= RR_INIT;
         lat_instr <= 32'd0;
         lat_type  <= 3'd0;
         res       <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (fire) begin
                  lat_instr <= grant ? req1_instr : req0_instr;
                  lat_type  <= grant ? req1_type : req0_type;
                  owner     <= grant;
                  state     <= GEN;
               end
            end
            GEN: begin
               res   <= gen_imm;
               state <= RESP;
            end
            RESP: begin
               if (rsp_fire) begin
                  prio <= ~owner;
                  if (fire) begin
                     lat_instr <= grant ? req1_instr : req0_instr;
                     lat_type  <= grant ? req1_type : req0_type;
                     owner     <= grant;
                     state     <= GEN;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
